// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory controller: FSM states, MMIO offsets, error word.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRAM,
        ST_DONE
    } state_t;

    localparam logic [15:0] KBSR_OFF = 16'h0000;
    localparam logic [15:0] KBDR_OFF = 16'h0002;
    localparam logic [15:0] DSR_OFF  = 16'h0004;
    localparam logic [15:0] DDR_OFF  = 16'h0006;
    localparam logic [15:0] ERR_WORD = 16'hDEAD;

endpackage

// File: rtl/mmio_regs.sv
// Keyboard/display MMIO registers with device handshakes and read mux.
// MEM_CTRL_KB_INT_EN adds a writable KBSR interrupt enable and the kb_irq output.
module mmio_regs
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        acc,
    input  logic        we,
    input  logic [15:0] offset,
    input  logic [7:0]  wdata_lo,
`ifdef MEM_CTRL_KB_INT_EN
    input  logic        wdata_ie,
    output logic        kb_irq,
`endif
    output logic [15:0] rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready
);

    logic       kb_ready;
    logic       kb_ie;
    logic [7:0] kbdr;
    logic       rd_kbdr;
    logic       wr_ddr;

    assign rd_kbdr = acc & ~we & (offset == KBDR_OFF);
    assign wr_ddr  = acc &  we & (offset == DDR_OFF);

    // A new character arriving in the same cycle as a KBDR read wins.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kb_ready <= 1'b0;
            kbdr     <= '0;
        end else if (kb_valid) begin
            kb_ready <= 1'b1;
            kbdr     <= kb_data;
        end else if (rd_kbdr) begin
            kb_ready <= 1'b0;
        end
    end

`ifdef MEM_CTRL_KB_INT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kb_ie  <= 1'b0;
            kb_irq <= 1'b0;
        end else begin
            if (acc && we && (offset == KBSR_OFF))
                kb_ie <= wdata_ie;
            kb_irq <= kb_ready & kb_ie;
        end
    end
`else
    assign kb_ie = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dd_valid <= 1'b0;
            dd_data  <= '0;
        end else if (wr_ddr) begin
            dd_valid <= 1'b1;
            dd_data  <= wdata_lo;
        end else if (dd_ready) begin
            dd_valid <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            KBSR_OFF: rdata = {kb_ready, kb_ie, 14'b0};
            KBDR_OFF: rdata = {8'h00, kbdr};
            DSR_OFF:  rdata = {~dd_valid, 15'b0};
            default:  rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, SRAM req/ack sequencing with timeout, MMIO decode.
// Optional keyboard interrupt (KBSR IE bit, kb_irq port): define MEM_CTRL_KB_INT_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE   = 16'hFE00,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        arst_n,
    inout  wire  [15:0] bus,
    input  logic        mem_ld_mar,
    input  logic        mem_ld_mdr,
    input  logic        mem_gate_mdr,
    input  logic        mem_mio_en,
    input  logic        mem_rw,
    output logic        mem_rdy,
    output logic        sram_req,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        sram_ack,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dd_valid,
    output logic [7:0]  dd_data,
    input  logic        dd_ready,
`ifdef MEM_CTRL_KB_INT_EN
    output logic        kb_irq,
`endif
    output logic        mem_err
);

    state_t      state, state_nxt;
    logic [15:0] mar, mdr, rd_buf;
    logic [15:0] mmio_rdata, mmio_off;
    logic [7:0]  to_cnt;
    logic        is_mmio, mmio_acc, timeout;

    assign is_mmio    = (mar >= MMIO_BASE);
    assign mmio_off   = mar - MMIO_BASE;
    assign bus        = mem_gate_mdr ? mdr : 'z;
    // Request decoded from state so an asynchronous reset drops it immediately.
    assign sram_req   = (state == ST_SRAM);
    assign sram_we    = sram_req & mem_rw;
    assign sram_addr  = mar;
    assign sram_wdata = mdr;

    always_comb begin
        state_nxt = state;
        mmio_acc  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_mio_en) begin
                    if (is_mmio) begin
                        state_nxt = ST_DONE;
                        mmio_acc  = 1'b1;
                    end else begin
                        state_nxt = ST_SRAM;
                    end
                end
            end
            ST_SRAM: begin
                if (sram_ack) begin
                    state_nxt = ST_DONE;
                end else if ((ACK_TIMEOUT != 8'd0) && (to_cnt == ACK_TIMEOUT - 8'd1)) begin
                    state_nxt = ST_DONE;
                    timeout   = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_IDLE;
            mem_rdy <= 1'b0;
            to_cnt  <= '0;
            rd_buf  <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_rdy <= (state_nxt == ST_DONE);
            to_cnt  <= (state == ST_SRAM) ? to_cnt + 8'd1 : '0;
            if (sram_req && sram_ack)
                rd_buf <= sram_rdata;
            else if (timeout)
                rd_buf <= ERR_WORD;
            else if (mmio_acc)
                rd_buf <= mmio_rdata;
            if (timeout)
                mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (mem_ld_mar)
                mar <= bus;
            if (mem_ld_mdr) begin
                if (!mem_mio_en)
                    mdr <= bus;
                else if (mem_rdy)
                    mdr <= rd_buf;
            end
        end
    end

    mmio_regs u_mmio (
        .clk      (clk),
        .arst_n   (arst_n),
        .acc      (mmio_acc),
        .we       (mem_rw),
        .offset   (mmio_off),
        .wdata_lo (mdr[7:0]),
`ifdef MEM_CTRL_KB_INT_EN
        .wdata_ie (mdr[14]),
        .kb_irq   (kb_irq),
`endif
        .rdata    (mmio_rdata),
        .kb_valid (kb_valid),
        .kb_data  (kb_data),
        .dd_valid (dd_valid),
        .dd_data  (dd_data),
        .dd_ready (dd_ready)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl (ACK_TIMEOUT overridden to 4).
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    wire  [15:0] bus;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    logic        mem_ld_mar = 1'b0, mem_ld_mdr = 1'b0, mem_gate_mdr = 1'b0;
    logic        mem_mio_en = 1'b0, mem_rw = 1'b0;
    logic        mem_rdy, sram_req, sram_we, sram_ack = 1'b0;
    logic [15:0] sram_addr, sram_wdata, sram_rdata = '0;
    logic        kb_valid = 1'b0, dd_ready = 1'b0, dd_valid, mem_err;
    logic [7:0]  kb_data = '0, dd_data;
`ifdef MEM_CTRL_KB_INT_EN
    logic        kb_irq;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic        snap_we;
    logic [15:0] snap_addr, snap_wdata;

    assign bus = drv_en ? drv_val : 'z;
    always #5 clk = ~clk;

    mem_ctrl #(.MMIO_BASE(16'hFE00), .ACK_TIMEOUT(8'd4)) dut (
        .clk(clk), .arst_n(arst_n), .bus(bus),
        .mem_ld_mar(mem_ld_mar), .mem_ld_mdr(mem_ld_mdr), .mem_gate_mdr(mem_gate_mdr),
        .mem_mio_en(mem_mio_en), .mem_rw(mem_rw), .mem_rdy(mem_rdy),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
        .kb_valid(kb_valid), .kb_data(kb_data), .dd_valid(dd_valid),
        .dd_data(dd_data), .dd_ready(dd_ready),
`ifdef MEM_CTRL_KB_INT_EN
        .kb_irq(kb_irq),
`endif
        .mem_err(mem_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [15:0] wdata;
        int          ack_after;
        logic [15:0] rdata;
        int          exp_lat;
        int          exp_req;
        logic [15:0] exp_mdr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_mar(input logic [15:0] a);
        @(negedge clk);
        drv_en = 1'b1; drv_val = a; mem_ld_mar = 1'b1;
        @(negedge clk);
        mem_ld_mar = 1'b0; drv_en = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        @(negedge clk);
        drv_en = 1'b1; drv_val = d; mem_ld_mdr = 1'b1; mem_mio_en = 1'b0;
        @(negedge clk);
        mem_ld_mdr = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_mdr(output logic [15:0] v);
        @(negedge clk);
        mem_gate_mdr = 1'b1;
        #1 v = bus;
        mem_gate_mdr = 1'b0;
    endtask

    // Latency counts negedges after the one where mio_en was raised.
    task automatic do_access(input logic rw, input int ack_after, input logic [15:0] rdata,
                             output int lat, output int rdy_cnt, output int req_cycles);
        @(negedge clk);
        mem_mio_en = 1'b1; mem_rw = rw; mem_ld_mdr = ~rw;
        lat = -1; rdy_cnt = 0; req_cycles = 0; snap_we = 1'b0; snap_addr = '0; snap_wdata = '0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            sram_ack = 1'b0;
            if (sram_req) begin
                req_cycles++;
                snap_we = sram_we; snap_addr = sram_addr; snap_wdata = sram_wdata;
                if (req_cycles == ack_after) begin
                    sram_ack = 1'b1; sram_rdata = rdata;
                end
            end
            if (mem_rdy) begin
                rdy_cnt++; lat = c;
                break;
            end
        end
        @(negedge clk);
        if (mem_rdy) rdy_cnt++;
        mem_mio_en = 1'b0; mem_ld_mdr = 1'b0; sram_ack = 1'b0;
        @(negedge clk);
        if (mem_rdy) rdy_cnt++;
    endtask

    task automatic mmio_read(input logic [15:0] a, output logic [15:0] v);
        int lat, rdy, req;
        load_mar(a);
        do_access(1'b0, 0, 16'h0000, lat, rdy, req);
        read_mdr(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int lat, rdy, req, seen;

        //         addr      rw    wdata     ack rdata     lat req mdr
        vecs[0] = '{16'hFE00, 1'b0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000};
        vecs[1] = '{16'h3000, 1'b0, 16'h0000, 3, 16'h1234, 4, 3, 16'h1234};
        vecs[2] = '{16'h4000, 1'b1, 16'hBEEF, 2, 16'h0000, 3, 2, 16'hBEEF};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 1, 16'hA5A5, 2, 1, 16'hA5A5};
        vecs[4] = '{16'hFDFF, 1'b0, 16'h0000, 1, 16'h5555, 2, 1, 16'h5555};
        vecs[5] = '{16'hFE10, 1'b0, 16'h0000, 1, 16'h9999, 1, 0, 16'h0000};
        vecs[6] = '{16'hFE08, 1'b1, 16'h1111, 1, 16'h0000, 1, 0, 16'h1111};
        vecs[7] = '{16'hFE04, 1'b0, 16'h0000, 0, 16'h0000, 1, 0, 16'h8000};

        repeat (2) @(negedge clk);
        chk("rst_mem_rdy", {15'b0, mem_rdy}, 16'h0000);
        chk("rst_sram_req", {15'b0, sram_req}, 16'h0000);
        chk("rst_sram_we", {15'b0, sram_we}, 16'h0000);
        chk("rst_dd_valid", {15'b0, dd_valid}, 16'h0000);
        chk("rst_mem_err", {15'b0, mem_err}, 16'h0000);
        chk("rst_mar", sram_addr, 16'h0000);
        chk("rst_mdr", sram_wdata, 16'h0000);
        arst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_mar(vecs[i].addr);
            load_mdr(vecs[i].rw ? vecs[i].wdata : 16'hCCCC);
            do_access(vecs[i].rw, vecs[i].ack_after, vecs[i].rdata, lat, rdy, req);
            chk($sformatf("v%0d_latency", i), 16'(lat), 16'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdy_pulses", i), 16'(rdy), 16'd1);
            chk($sformatf("v%0d_req_cycles", i), 16'(req), 16'(vecs[i].exp_req));
            read_mdr(v);
            chk($sformatf("v%0d_mdr", i), v, vecs[i].exp_mdr);
            if (vecs[i].rw && vecs[i].exp_req != 0) begin
                chk($sformatf("v%0d_sram_we", i), {15'b0, snap_we}, 16'h0001);
                chk($sformatf("v%0d_sram_addr", i), snap_addr, vecs[i].addr);
                chk($sformatf("v%0d_sram_wdata", i), snap_wdata, vecs[i].wdata);
            end
        end

        // SRAM timeout: no ack, four request cycles, error word and sticky mem_err
        chk("pre_timeout_err", {15'b0, mem_err}, 16'h0000);
        load_mar(16'h3000);
        load_mdr(16'hCCCC);
        do_access(1'b0, 0, 16'h0000, lat, rdy, req);
        chk("to_latency", 16'(lat), 16'd5);
        chk("to_req_cycles", 16'(req), 16'd4);
        chk("to_rdy_pulses", 16'(rdy), 16'd1);
        read_mdr(v);
        chk("to_mdr", v, 16'hDEAD);
        chk("to_mem_err", {15'b0, mem_err}, 16'h0001);
        load_mar(16'h3002);
        do_access(1'b0, 1, 16'h7777, lat, rdy, req);
        read_mdr(v);
        chk("after_to_mdr", v, 16'h7777);
        chk("mem_err_sticky", {15'b0, mem_err}, 16'h0001);

        // Keyboard
        @(negedge clk); kb_valid = 1'b1; kb_data = 8'h41;
        @(negedge clk); kb_valid = 1'b0;
        mmio_read(16'hFE00, v); chk("kbsr_ready", v, 16'h8000);
        mmio_read(16'hFE02, v); chk("kbdr_char", v, 16'h0041);
        mmio_read(16'hFE00, v); chk("kbsr_cleared", v, 16'h0000);
        @(negedge clk); kb_valid = 1'b1; kb_data = 8'h41;
        @(negedge clk); kb_data = 8'h42;
        @(negedge clk); kb_valid = 1'b0;
        mmio_read(16'hFE02, v); chk("kbdr_overwrite", v, 16'h0042);

        // Display
        load_mar(16'hFE06);
        load_mdr(16'h0058);
        do_access(1'b1, 0, 16'h0000, lat, rdy, req);
        chk("ddr_write_lat", 16'(lat), 16'd1);
        chk("dd_valid_set", {15'b0, dd_valid}, 16'h0001);
        chk("dd_data", {8'h00, dd_data}, 16'h0058);
        mmio_read(16'hFE04, v); chk("dsr_busy", v, 16'h0000);
        @(negedge clk); dd_ready = 1'b1;
        @(negedge clk); dd_ready = 1'b0;
        chk("dd_valid_clear", {15'b0, dd_valid}, 16'h0000);
        mmio_read(16'hFE04, v); chk("dsr_ready", v, 16'h8000);

        // Reset in the middle of an SRAM access
        load_mar(16'h3000);
        @(negedge clk); mem_mio_en = 1'b1; mem_rw = 1'b0;
        @(negedge clk);
        chk("mid_req_up", {15'b0, sram_req}, 16'h0001);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_req_drop", {15'b0, sram_req}, 16'h0000);
        chk("mid_rdy_low", {15'b0, mem_rdy}, 16'h0000);
        mem_mio_en = 1'b0;
        @(negedge clk); arst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_rdy || sram_req) seen++;
        end
        chk("post_rst_idle", 16'(seen), 16'd0);
        chk("post_rst_mar", sram_addr, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
